// File: rtl/adc_responder.sv
// adc_responder
//    SPI slave that emulates an AD7908 (8 channels, 8 bits) for loopback and
//    self-test. Decodes the 12-bit control word shifted in on spi_din and
//    returns 16-bit frames {0, addr[2:0], sample[7:0], 4'b0000} on spi_dout.
//    The address written in one frame selects the channel of the next one.
//
// Ports
//    clk, rst      system clock, synchronous active-high reset
//    spi_sclk      SPI clock from master (idle low), asynchronous
//    spi_cs_n      chip select, active low, asynchronous
//    spi_din       MOSI, control word MSB first, asynchronous
//    ch_data       channel samples, channel k at [8k+7:8k]
//    spi_dout      MISO
//    dout_oe       high while a frame is active
//    cur_addr      channel converted on the next CS fall
//    ctrl_word     last committed control word
//    frame_done    one-clk pulse at the end of a complete frame
//    frame_err     one-clk pulse when CS rises before the 16th SCLK fall
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no frame; waiting for a CS fall
// SHIFT   | frame active, shifting on SCLK falls (bit_cnt = falls seen)
// WAIT_CS | all 16 falls seen and committed; waiting for CS to rise

module adc_responder #(
   parameter logic [2:0] RESET_ADDR  = 3'd0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_din,
   input  logic [63:0] ch_data,
   output logic        spi_dout,
   output logic        dout_oe,
   output logic [2:0]  cur_addr,
   output logic [11:0] ctrl_word,
   output logic        frame_done,
   output logic        frame_err
);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

   state_t state, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
   logic sclk_hist, cs_hist;
   logic sclk_s, cs_s, din_s;
   logic cs_fall, cs_rise, sclk_fall;

   logic [4:0]  bit_cnt, bit_cnt_d;
   logic [15:0] tx, tx_d;
   logic [15:0] rx, rx_d, rx_shift;
   logic        dout_d, oe_d, done_d, err_d;
   logic [2:0]  addr_d;
   logic [11:0] ctrl_d;

   // Synchronizers and history flops reset to 0, so a CS that is already
   // low when reset is released never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         din_sync  <= '0;
         sclk_hist <= 1'b0;
         cs_hist   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], spi_din};
         sclk_hist <= sclk_s;
         cs_hist   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign cs_fall   = cs_hist & ~cs_s;
   assign cs_rise   = ~cs_hist & cs_s;
   assign sclk_fall = sclk_hist & ~sclk_s;
   assign rx_shift  = {rx[14:0], din_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         tx         <= '0;
         rx         <= '0;
         spi_dout   <= 1'b0;
         dout_oe    <= 1'b0;
         cur_addr   <= RESET_ADDR;
         ctrl_word  <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_d;
         bit_cnt    <= bit_cnt_d;
         tx         <= tx_d;
         rx         <= rx_d;
         spi_dout   <= dout_d;
         dout_oe    <= oe_d;
         cur_addr   <= addr_d;
         ctrl_word  <= ctrl_d;
         frame_done <= done_d;
         frame_err  <= err_d;
      end
   end

   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      tx_d      = tx;
      rx_d      = rx;
      dout_d    = spi_dout;
      oe_d      = dout_oe;
      addr_d    = cur_addr;
      ctrl_d    = ctrl_word;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state)
         IDLE: begin
            if (cs_fall) begin
               // Sample is frozen here; later ch_data changes do not matter.
               tx_d      = {1'b0, cur_addr, ch_data[{cur_addr, 3'b000} +: 8], 4'b0000};
               dout_d    = tx_d[15];
               oe_d      = 1'b1;
               bit_cnt_d = '0;
               rx_d      = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // CS rise beats a coincident SCLK fall, even the 16th one.
            if (cs_rise) begin
               err_d   = 1'b1;
               dout_d  = 1'b0;
               oe_d    = 1'b0;
               state_d = IDLE;
            end else if (sclk_fall) begin
               rx_d      = rx_shift;
               bit_cnt_d = bit_cnt + 5'd1;
               // tx shifts left with zero fill, so tx[14] is the next bit
               // and naturally becomes 0 on the 16th fall.
               dout_d    = tx[14];
               tx_d      = {tx[14:0], 1'b0};
               if (bit_cnt == 5'd15) begin
                  dout_d  = 1'b0;
                  state_d = WAIT_CS;
                  if (rx_shift[15]) begin
                     ctrl_d = rx_shift[15:4];
                     addr_d = rx_shift[12:10];
                  end
               end
            end
         end
         WAIT_CS: begin
            dout_d = 1'b0;
            if (cs_rise) begin
               done_d  = 1'b1;
               oe_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_adc_responder.sv
module tb_adc_responder;

   localparam int H = 8;   // SCLK half-period in clk cycles

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sclk, spi_cs_n, spi_din;
   logic [63:0] ch_data;
   logic        spi_dout, dout_oe;
   logic [2:0]  cur_addr;
   logic [11:0] ctrl_word;
   logic        frame_done, frame_err;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   adc_responder #(.RESET_ADDR(3'd0), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_din(spi_din),
      .ch_data(ch_data),
      .spi_dout(spi_dout), .dout_oe(dout_oe),
      .cur_addr(cur_addr), .ctrl_word(ctrl_word),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // {WRITE, SEQ=0, DONTC=0, ADD[2:0], PM=11, SHADOW=0, DONTC=0, RANGE=1, CODING=1, 4'b0}
   function automatic logic [15:0] mk_din(input logic wr, input logic [2:0] a);
      return {wr, 2'b00, a, 6'b110011, 4'b0000};
   endfunction

   task automatic spi_xfer(input logic [15:0] din_w, input int nfalls, input int extra,
                           input int mid_at, input logic [63:0] mid_data, input bit race,
                           output logic [15:0] dout_w);
      dout_w = '0;
      spi_cs_n = 1'b0;
      wait_clk(H);
      for (int i = 0; i < nfalls; i++) begin
         if (i == mid_at) ch_data = mid_data;
         spi_din  = din_w[15-i];
         spi_sclk = 1'b1;
         wait_clk(H);
         dout_w[15-i] = spi_dout;
         spi_sclk = 1'b0;
         if (race && i == nfalls-1) spi_cs_n = 1'b1;
         wait_clk(H);
      end
      for (int e = 0; e < extra; e++) begin
         spi_sclk = 1'b1;
         wait_clk(H);
         checks++;
         if (spi_dout !== 1'b0) begin
            errors++;
            $display("FAIL extra_pulse_dout: got %b expected 0", spi_dout);
         end
         spi_sclk = 1'b0;
         wait_clk(H);
      end
      spi_cs_n = 1'b1;
      spi_din  = 1'b0;
      wait_clk(H);
   endtask

   task automatic test_reset();
      rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_din = 1'b0; ch_data = '0;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      checks++; if (spi_dout !== 1'b0)   begin errors++; $display("FAIL reset_dout: got %b expected 0", spi_dout); end
      checks++; if (dout_oe !== 1'b0)    begin errors++; $display("FAIL reset_oe: got %b expected 0", dout_oe); end
      checks++; if (cur_addr !== 3'd0)   begin errors++; $display("FAIL reset_addr: got %0d expected 0", cur_addr); end
      checks++; if (ctrl_word !== 12'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 000", ctrl_word); end
      checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0)
         begin errors++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", frame_done, frame_err); end
   endtask

   task automatic test_write_frame();
      logic [15:0] d;
      int d0;
      d0 = done_cnt;
      ch_data[7:0] = 8'hA5;
      spi_xfer(mk_din(1'b1, 3'd3), 16, 0, -1, '0, 1'b0, d);
      checks++; if (d !== 16'h0A50)       begin errors++; $display("FAIL write_dout: got %h expected 0a50", d); end
      checks++; if (done_cnt - d0 !== 1)  begin errors++; $display("FAIL write_done: got %0d expected 1", done_cnt - d0); end
      checks++; if (cur_addr !== 3'd3)    begin errors++; $display("FAIL write_addr: got %0d expected 3", cur_addr); end
      checks++; if (ctrl_word !== 12'h8F3) begin errors++; $display("FAIL write_ctrl: got %h expected 8f3", ctrl_word); end
      checks++; if (dout_oe !== 1'b0)     begin errors++; $display("FAIL write_oe_after: got %b expected 0", dout_oe); end
   endtask

   task automatic test_read_frame();
      logic [15:0] d;
      ch_data[31:24] = 8'h3C;
      spi_xfer(mk_din(1'b0, 3'd5), 16, 0, -1, '0, 1'b0, d);
      checks++; if (d !== 16'h33C0)        begin errors++; $display("FAIL read_dout: got %h expected 33c0", d); end
      checks++; if (cur_addr !== 3'd3)     begin errors++; $display("FAIL read_addr: got %0d expected 3", cur_addr); end
      checks++; if (ctrl_word !== 12'h8F3) begin errors++; $display("FAIL read_ctrl: got %h expected 8f3", ctrl_word); end
   endtask

   task automatic test_pipeline();
      logic [15:0] d;
      logic [15:0] exp_d [4] = '{16'h33C0, 16'h0120, 16'h1EF0, 16'h0120};
      ch_data[7:0]  = 8'h12;
      ch_data[15:8] = 8'hEF;
      for (int f = 0; f < 4; f++) begin
         spi_xfer(mk_din(1'b1, 3'(f % 2)), 16, 0, -1, '0, 1'b0, d);
         checks++;
         if (d !== exp_d[f]) begin errors++; $display("FAIL pipe_dout[%0d]: got %h expected %h", f, d, exp_d[f]); end
      end
      checks++; if (cur_addr !== 3'd1)     begin errors++; $display("FAIL pipe_addr: got %0d expected 1", cur_addr); end
      checks++; if (ctrl_word !== 12'h873) begin errors++; $display("FAIL pipe_ctrl: got %h expected 873", ctrl_word); end
   endtask

   task automatic test_abort();
      logic [15:0] d;
      logic [15:0] exp_d;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      exp_d = 16'h1EF0;
      spi_xfer(mk_din(1'b1, 3'd5), 9, 0, -1, '0, 1'b0, d);
      checks++; if (d[15:7] !== exp_d[15:7]) begin errors++; $display("FAIL abort_bits: got %h expected %h", d[15:7], exp_d[15:7]); end
      checks++; if (err_cnt - e0 !== 1)      begin errors++; $display("FAIL abort_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (done_cnt - d0 !== 0)     begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
      checks++; if (cur_addr !== 3'd1)       begin errors++; $display("FAIL abort_addr: got %0d expected 1", cur_addr); end
      checks++; if (dout_oe !== 1'b0 || spi_dout !== 1'b0)
         begin errors++; $display("FAIL abort_outputs: got oe=%b dout=%b expected 0 0", dout_oe, spi_dout); end
   endtask

   task automatic test_cs_race();
      logic [15:0] d;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      spi_xfer(mk_din(1'b1, 3'd6), 16, 0, -1, '0, 1'b1, d);
      checks++; if (err_cnt - e0 !== 1)    begin errors++; $display("FAIL race_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (done_cnt - d0 !== 0)   begin errors++; $display("FAIL race_done: got %0d expected 0", done_cnt - d0); end
      checks++; if (cur_addr !== 3'd1)     begin errors++; $display("FAIL race_addr: got %0d expected 1", cur_addr); end
      checks++; if (ctrl_word !== 12'h873) begin errors++; $display("FAIL race_ctrl: got %h expected 873", ctrl_word); end
   endtask

   task automatic test_mid_change_extra();
      logic [15:0] d;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      spi_xfer(mk_din(1'b1, 3'd2), 16, 3, 4, {8{8'h55}}, 1'b0, d);
      checks++; if (d !== 16'h1EF0)        begin errors++; $display("FAIL mid_dout: got %h expected 1ef0", d); end
      checks++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
         begin errors++; $display("FAIL mid_pulses: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0); end
      checks++; if (cur_addr !== 3'd2)     begin errors++; $display("FAIL mid_addr: got %0d expected 2", cur_addr); end
      checks++; if (ctrl_word !== 12'h8B3) begin errors++; $display("FAIL mid_ctrl: got %h expected 8b3", ctrl_word); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d;
      logic [15:0] w;
      int d0, e0;
      ch_data[7:0] = 8'hC3;
      w = mk_din(1'b1, 3'd4);
      spi_cs_n = 1'b0;
      wait_clk(H);
      for (int i = 0; i < 8; i++) begin
         spi_din = w[15-i]; spi_sclk = 1'b1; wait_clk(H);
         spi_sclk = 1'b0; wait_clk(H);
      end
      checks++; if (dout_oe !== 1'b1) begin errors++; $display("FAIL rstmid_oe_active: got %b expected 1", dout_oe); end
      rst = 1'b1;
      wait_clk(2);
      checks++; if (spi_dout !== 1'b0 || dout_oe !== 1'b0)
         begin errors++; $display("FAIL rstmid_outputs: got dout=%b oe=%b expected 0 0", spi_dout, dout_oe); end
      checks++; if (cur_addr !== 3'd0)   begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", cur_addr); end
      checks++; if (ctrl_word !== 12'h0) begin errors++; $display("FAIL rstmid_ctrl: got %h expected 000", ctrl_word); end
      rst = 1'b0;
      d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < 4; i++) begin
         spi_sclk = 1'b1; wait_clk(H);
         spi_sclk = 1'b0; wait_clk(H);
      end
      checks++; if (dout_oe !== 1'b0) begin errors++; $display("FAIL rstmid_no_start: got oe=%b expected 0", dout_oe); end
      spi_cs_n = 1'b1;
      wait_clk(H);
      checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0)
         begin errors++; $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0); end
      spi_xfer(mk_din(1'b0, 3'd0), 16, 0, -1, '0, 1'b0, d);
      checks++; if (d !== 16'h0C30) begin errors++; $display("FAIL rstmid_new_frame: got %h expected 0c30", d); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_new_done: got %0d expected 1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_read_frame();
      test_pipeline();
      test_abort();
      test_cs_race();
      test_mid_change_extra();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
